// File: rtl/sbentsrc_pkg.sv
// Shared types and elaboration helpers for the S-box entropy source post-processor.
package sbentsrc_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StStartup,
        StRun,
        StAlarm
    } state_e;

    // Bits needed to hold values 0..n-1 (never zero wide).
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic bit params_ok(input int unsigned rng_w, input int unsigned out_w,
                                     input int unsigned startup, input int unsigned rct_cut,
                                     input int unsigned apt_win, input int unsigned apt_cut);
        return (rng_w > 0) && (rng_w % 4 == 0) && (out_w >= rng_w) && (out_w % rng_w == 0) &&
               (startup >= 1) && (rct_cut >= 2) && (apt_win >= 2) &&
               ((apt_win & (apt_win - 1)) == 0) && (apt_cut >= 2) && (apt_cut <= apt_win);
    endfunction

endpackage

// File: rtl/sbentsrc_health.sv
// Repetition-count and adaptive-proportion health tests on one sample stream.
module sbentsrc_health
    import sbentsrc_pkg::*;
#(
    parameter int unsigned RNG_WIDTH  = 4,
    parameter int unsigned RCT_CUTOFF = 8,
    parameter int unsigned APT_WINDOW = 64,
    parameter int unsigned APT_CUTOFF = 24
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    input  logic [RNG_WIDTH-1:0] i_sample,
    input  logic                 i_sample_en,
    input  logic                 i_restart,
    output logic                 o_rct_fail,
    output logic                 o_apt_fail
);

    localparam int unsigned RctW = cnt_width(RCT_CUTOFF + 1);
    localparam int unsigned WinW = $clog2(APT_WINDOW);
    localparam int unsigned AptW = cnt_width(APT_WINDOW + 1);

    logic [RNG_WIDTH-1:0] prev_q, prev_d, ref_q, ref_d;
    logic [RctW-1:0]      run_q, run_d;
    logic [WinW-1:0]      win_q, win_d;
    logic [AptW-1:0]      apt_q, apt_d;

    always_comb begin
        prev_d = prev_q;
        run_d  = run_q;
        ref_d  = ref_q;
        win_d  = win_q;
        apt_d  = apt_q;
        if (i_sample_en) begin
            prev_d = i_sample;
            if (i_restart || (i_sample != prev_q)) begin
                run_d = RctW'(1);
            end else if (run_q != RctW'(RCT_CUTOFF)) begin
                run_d = run_q + 1'b1;
            end
            // Window position wraps naturally because APT_WINDOW is a power of two.
            if (i_restart || (win_q == '0)) begin
                ref_d = i_sample;
                apt_d = AptW'(1);
                win_d = WinW'(1);
            end else begin
                win_d = win_q + 1'b1;
                if (i_sample == ref_q) begin
                    apt_d = apt_q + 1'b1;
                end
            end
        end
    end

    assign o_rct_fail = i_sample_en && (run_d == RctW'(RCT_CUTOFF));
    assign o_apt_fail = i_sample_en && (apt_d == AptW'(APT_CUTOFF));

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            prev_q <= '0;
            run_q  <= '0;
            ref_q  <= '0;
            win_q  <= '0;
            apt_q  <= '0;
        end else begin
            prev_q <= prev_d;
            run_q  <= run_d;
            ref_q  <= ref_d;
            win_q  <= win_d;
            apt_q  <= apt_d;
        end
    end

endmodule

// File: rtl/sbentsrc_postproc.sv
// Entropy source post-processor: start-up discard, health-test alarms, sample packing and
// valid/ready output register.
module sbentsrc_postproc
    import sbentsrc_pkg::*;
#(
    parameter int unsigned RNG_WIDTH       = 4,
    parameter int unsigned OUT_WIDTH       = 32,
    parameter int unsigned STARTUP_SAMPLES = 64,
    parameter int unsigned RCT_CUTOFF      = 8,
    parameter int unsigned APT_WINDOW      = 64,
    parameter int unsigned APT_CUTOFF      = 24
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    input  logic                 i_start,
    input  logic                 i_clear,
    output logic                 o_src_en,
    input  logic [RNG_WIDTH-1:0] i_rnd,
    output logic [OUT_WIDTH-1:0] o_data,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic                 o_rct_alarm,
    output logic                 o_apt_alarm,
    output logic                 o_drop,
    output logic                 o_busy
);

    localparam int unsigned Words  = OUT_WIDTH / RNG_WIDTH;
    localparam int unsigned IdxW   = cnt_width(Words);
    localparam int unsigned StartW = cnt_width(STARTUP_SAMPLES);

    if (!params_ok(RNG_WIDTH, OUT_WIDTH, STARTUP_SAMPLES, RCT_CUTOFF, APT_WINDOW, APT_CUTOFF))
    begin : g_bad_params
        $error("sbentsrc_postproc: illegal parameter combination");
    end

    state_e               state_q, state_d;
    logic                 src_en_q, src_en_d;
    logic [StartW-1:0]    start_cnt_q, start_cnt_d;
    logic [IdxW-1:0]      idx_q, idx_d;
    logic [OUT_WIDTH-1:0] acc_q, acc_d, data_q, data_d, word_c;
    logic                 valid_q, valid_d;
    logic                 rct_q, rct_d, apt_q, apt_d, drop_q, drop_d;
    logic                 sample_en, restart, rct_fail, apt_fail, fail;

    assign sample_en = (state_q == StStartup) || (state_q == StRun);
    assign restart   = (state_q == StStartup) && (start_cnt_q == '0);
    assign fail      = rct_fail || apt_fail;

    sbentsrc_health #(
        .RNG_WIDTH (RNG_WIDTH),
        .RCT_CUTOFF(RCT_CUTOFF),
        .APT_WINDOW(APT_WINDOW),
        .APT_CUTOFF(APT_CUTOFF)
    ) u_health (
        .i_clk      (i_clk),
        .i_reset_n  (i_reset_n),
        .i_sample   (i_rnd),
        .i_sample_en(sample_en),
        .i_restart  (restart),
        .o_rct_fail (rct_fail),
        .o_apt_fail (apt_fail)
    );

    always_comb begin
        state_d     = state_q;
        start_cnt_d = start_cnt_q;
        idx_d       = idx_q;
        acc_d       = acc_q;
        data_d      = data_q;
        valid_d     = valid_q;
        rct_d       = rct_q;
        apt_d       = apt_q;
        drop_d      = drop_q;
        word_c      = acc_q;
        word_c[idx_q*RNG_WIDTH +: RNG_WIDTH] = i_rnd;

        if (i_clear) begin
            rct_d  = 1'b0;
            apt_d  = 1'b0;
            drop_d = 1'b0;
        end
        if (valid_q && i_ready) begin
            valid_d = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                if (i_start) begin
                    state_d     = StStartup;
                    start_cnt_d = '0;
                end
            end
            StStartup: begin
                if (start_cnt_q == StartW'(STARTUP_SAMPLES - 1)) begin
                    state_d     = StRun;
                    start_cnt_d = '0;
                end else begin
                    start_cnt_d = start_cnt_q + 1'b1;
                end
            end
            StRun: begin
                if (!fail) begin
                    acc_d = word_c;
                    if (idx_q == IdxW'(Words - 1)) begin
                        idx_d = '0;
                        if (!valid_q || i_ready) begin
                            data_d  = word_c;
                            valid_d = 1'b1;
                        end else begin
                            drop_d = 1'b1;
                        end
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            StAlarm: begin
                if (i_clear) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // A failing sample flushes everything in flight; it also beats a same-cycle clear.
        if (fail) begin
            state_d     = StAlarm;
            start_cnt_d = '0;
            idx_d       = '0;
            acc_d       = '0;
            data_d      = '0;
            valid_d     = 1'b0;
        end
        rct_d = rct_d | rct_fail;
        apt_d = apt_d | apt_fail;

        src_en_d = (state_d == StStartup) || (state_d == StRun);
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q     <= StIdle;
            src_en_q    <= 1'b0;
            start_cnt_q <= '0;
            idx_q       <= '0;
            acc_q       <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            rct_q       <= 1'b0;
            apt_q       <= 1'b0;
            drop_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            src_en_q    <= src_en_d;
            start_cnt_q <= start_cnt_d;
            idx_q       <= idx_d;
            acc_q       <= acc_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            rct_q       <= rct_d;
            apt_q       <= apt_d;
            drop_q      <= drop_d;
        end
    end

    assign o_src_en    = src_en_q;
    assign o_data      = data_q;
    assign o_valid     = valid_q;
    assign o_rct_alarm = rct_q;
    assign o_apt_alarm = apt_q;
    assign o_drop      = drop_q;
    assign o_busy      = sample_en;

endmodule

// File: tb/tb_sbentsrc_postproc.sv
// Directed bench for sbentsrc_postproc: start-up timing, packing, back-pressure, RCT/APT
// alarms, clear and asynchronous reset.
module tb_sbentsrc_postproc;

    logic        i_clk = 1'b0;
    logic        i_reset_n = 1'b0;
    logic        i_start = 1'b0;
    logic        i_clear = 1'b0;
    logic        i_ready = 1'b0;
    logic [3:0]  i_rnd = 4'h0;
    logic        o_src_en, o_valid, o_rct_alarm, o_apt_alarm, o_drop, o_busy;
    logic [31:0] o_data;

    int n_vec = 0;
    int n_err = 0;

    sbentsrc_postproc dut (
        .i_clk      (i_clk),
        .i_reset_n  (i_reset_n),
        .i_start    (i_start),
        .i_clear    (i_clear),
        .o_src_en   (o_src_en),
        .i_rnd      (i_rnd),
        .o_data     (o_data),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_rct_alarm(o_rct_alarm),
        .o_apt_alarm(o_apt_alarm),
        .o_drop     (o_drop),
        .o_busy     (o_busy)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic feed(input logic [3:0] v);
        i_rnd = v;
        tick();
    endtask

    // Window 0 holds 23 copies of its reference 4'h3, later windows hold more.
    function automatic logic [3:0] apt_pat(input int s);
        int w;
        int lim;
        w   = s % 64;
        lim = (s < 64) ? 44 : 62;
        if (w <= lim) return (w % 2 == 0) ? 4'h3 : 4'h5;
        return (w % 2 == 1) ? 4'h5 : 4'h6;
    endfunction

    initial begin
        // Reset state
        #1;
        check("rst_src_en", 32'(o_src_en), 32'd0);
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_data", o_data, 32'd0);
        check("rst_rct", 32'(o_rct_alarm), 32'd0);
        check("rst_apt", 32'(o_apt_alarm), 32'd0);
        check("rst_drop", 32'(o_drop), 32'd0);
        check("rst_busy", 32'(o_busy), 32'd0);
        tick();
        i_reset_n = 1'b1;
        tick();

        // Normal run: samples are s mod 16
        i_ready = 1'b1;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        check("start_src_en", 32'(o_src_en), 32'd1);
        check("start_busy", 32'(o_busy), 32'd1);
        for (int s = 0; s < 71; s++) feed(4'(s));
        check("no_early_valid", 32'(o_valid), 32'd0);
        feed(4'd7);
        check("word0_valid", 32'(o_valid), 32'd1);
        check("word0_data", o_data, 32'h7654_3210);
        feed(4'h8);
        check("word0_taken", 32'(o_valid), 32'd0);
        for (int s = 73; s < 80; s++) feed(4'(s));
        check("word1_valid", 32'(o_valid), 32'd1);
        check("word1_data", o_data, 32'hFEDC_BA98);

        // Back-pressure: held word stays, next completed word is dropped
        i_ready = 1'b0;
        for (int s = 80; s < 84; s++) feed(4'(s));
        check("hold_data", o_data, 32'hFEDC_BA98);
        check("hold_drop", 32'(o_drop), 32'd0);
        for (int s = 84; s < 88; s++) feed(4'(s));
        check("drop_set", 32'(o_drop), 32'd1);
        check("drop_valid", 32'(o_valid), 32'd1);
        check("drop_data", o_data, 32'hFEDC_BA98);
        i_ready = 1'b1;
        feed(4'h8);
        check("held_taken", 32'(o_valid), 32'd0);
        i_clear = 1'b1;
        feed(4'h9);
        i_clear = 1'b0;
        check("clear_drop", 32'(o_drop), 32'd0);
        check("clear_busy", 32'(o_busy), 32'd1);
        for (int s = 90; s < 96; s++) feed(4'(s));
        check("word3_valid", 32'(o_valid), 32'd1);

        // Asynchronous reset mid-RUN
        i_reset_n = 1'b0;
        #1;
        check("arst_valid", 32'(o_valid), 32'd0);
        check("arst_data", o_data, 32'd0);
        check("arst_src_en", 32'(o_src_en), 32'd0);
        check("arst_busy", 32'(o_busy), 32'd0);
        tick();
        i_reset_n = 1'b1;
        tick();
        tick();
        tick();
        check("idle_busy", 32'(o_busy), 32'd0);
        check("idle_src_en", 32'(o_src_en), 32'd0);

        // RCT: constant 4'hA
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        for (int s = 0; s < 7; s++) feed(4'hA);
        check("rct_pre", 32'(o_rct_alarm), 32'd0);
        check("rct_pre_src_en", 32'(o_src_en), 32'd1);
        feed(4'hA);
        check("rct_alarm", 32'(o_rct_alarm), 32'd1);
        check("rct_src_en", 32'(o_src_en), 32'd0);
        check("rct_busy", 32'(o_busy), 32'd0);
        check("rct_apt", 32'(o_apt_alarm), 32'd0);
        check("rct_valid", 32'(o_valid), 32'd0);

        // ALARM ignores start, clear returns to IDLE, start repeats full startup
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        check("alarm_start_ign", 32'(o_src_en), 32'd0);
        check("alarm_sticky", 32'(o_rct_alarm), 32'd1);
        i_clear = 1'b1;
        tick();
        i_clear = 1'b0;
        check("clr_rct", 32'(o_rct_alarm), 32'd0);
        tick();
        check("clr_idle", 32'(o_busy), 32'd0);
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        check("restart_src_en", 32'(o_src_en), 32'd1);
        for (int s = 0; s < 71; s++) feed(4'(s));
        check("restart_no_valid", 32'(o_valid), 32'd0);
        feed(4'd7);
        check("restart_valid", 32'(o_valid), 32'd1);
        check("restart_data", o_data, 32'h7654_3210);

        // APT: 23 matches in window 0, 24 in window 1
        i_reset_n = 1'b0;
        tick();
        i_reset_n = 1'b1;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        for (int s = 0; s < 64; s++) feed(apt_pat(s));
        check("apt_23_no_alarm", 32'(o_apt_alarm), 32'd0);
        feed(apt_pat(64));
        check("apt_win_restart", 32'(o_apt_alarm), 32'd0);
        for (int s = 65; s < 110; s++) feed(apt_pat(s));
        check("apt_pre", 32'(o_apt_alarm), 32'd0);
        check("apt_pre_src_en", 32'(o_src_en), 32'd1);
        feed(apt_pat(110));
        check("apt_alarm", 32'(o_apt_alarm), 32'd1);
        check("apt_rct", 32'(o_rct_alarm), 32'd0);
        check("apt_src_en", 32'(o_src_en), 32'd0);
        check("apt_valid", 32'(o_valid), 32'd0);
        check("apt_busy", 32'(o_busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
